elixirchip_es1_spu_op_addsub_acc: RTL and testbench
===================================================

Name: elixirchip_es1_spu_op_addsub_acc

Overview:
- Next-generation SPU adder op: multi-lane (SIMD) add/subtract with an optional per-lane accumulator.
- LATENCY-deep pipeline with cke, clear and valid qualification.
- Sits alongside the single-lane SPU add op; instantiated by Elixir-generated wrappers with parameters rewritten before build.

Parameters:
- LATENCY, 1: input-to-output cycles; must be >=1.
- LANES, 1: number of independent lanes.
- DATA_BITS, 8: bits per lane.
- CLEAR_DATA, 0: value loaded into m_data and the accumulator on clear or reset.
- CLEAR_CARRY, 0: value loaded into m_carry on clear or reset.
- IMMEDIATE_DATA1, 0: s_data1 is constant; its input register may be optimised away.
- USE_CLEAR, 1: 0 ties s_clear internally to 0.
- USE_VALID, 1: 0 ties s_valid internally to 1.
- DEVICE, "RTL": target device.
- SIMULATION, "false": simulation mode.
- DEBUG, "false": debug mode.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- cke  in  1  clock enable; when low, all state holds.
- s_mode  in  2  00 ADD, 01 SUB, 10 ACC_ADD, 11 ACC_SUB.
- s_carry  in  LANES  per-lane carry-in; for subtract, 1 means no borrow.
- s_data0  in  LANES*DATA_BITS  operand 0; lane i occupies bits [i*DATA_BITS +: DATA_BITS].
- s_data1  in  LANES*DATA_BITS  operand 1.
- s_clear  in  1  clear pipeline and accumulators.
- s_valid  in  1  input beat valid.
- m_data  out  LANES*DATA_BITS  result.
- m_carry  out  LANES  carry-out of each lane's MSB.
- m_msb_c  out  LANES  carry into each lane's MSB; signed overflow = m_carry ^ m_msb_c.
- m_valid  out  1  output beat valid.

Behaviour:
- Per lane, stage 0:
  - b = SUB modes ? ~s_data1 : s_data1.
  - a = ACC modes ? acc : s_data0.
  - {cout, sum} = a + b + s_carry, computed DATA_BITS+1 wide.
  - msb_c = carry into bit DATA_BITS-1.
- Lanes are fully independent; no carry crosses a lane boundary.
- Accumulator update: when cke & s_valid & ~s_clear in an ACC mode, acc <= sum. In ADD/SUB modes acc is unchanged.
- Overflow wraps modulo 2^DATA_BITS unless the optional feature is enabled.
- Pipeline: stage 0 registers the result. Stages 1..LATENCY-1 are pure delay registers, each advancing only when cke=1.
- Total latency is exactly LATENCY cycles from the input beat to m_data/m_valid.
- Valid handling: m_valid is s_valid delayed LATENCY cycles. Data/carry registers at a stage load only when that stage's valid=1; otherwise they hold the last value.
- Clear (cke=1 & s_clear=1):
  - acc <= CLEAR_DATA.
  - The stage-0 result becomes CLEAR_DATA/CLEAR_CARRY, with msb_c=0.
  - The cleared beat carries m_valid = s_valid and flows through the remaining stages normally.
- Clear and valid together: clear wins for data and accumulator; valid still propagates.
- cke=0: every register, including acc and the valid pipe, holds; inputs are ignored.
- Reset low, at any time (including mid-beat or mid-accumulation), asynchronously forces:
  - m_data = CLEAR_DATA, m_carry = CLEAR_CARRY, m_msb_c = 0, m_valid = 0.
  - All acc = CLEAR_DATA and all internal stages cleared.
- The first beat after reset release follows normal latency.
- A mode change between beats takes effect on the next beat; acc persists across ADD/SUB beats.

Optional Feature:
- Macro: ELIXIRCHIP_ES1_SPU_OP_ADDSUB_SATURATE_EN.
- Defined: unsigned saturation per lane.
  - Add modes: cout=1 forces the result to all-ones.
  - Sub modes: cout=0 (borrow) forces the result to 0.
  - The saturated value is also what the accumulator stores.
  - m_carry/m_msb_c still report the raw unsaturated flags.
- Undefined: wrap-around only; no saturation logic is instantiated.

Decomposition:
- Package elixirchip_es1_spu_pkg holds:
  - mode_t enum: ADD, SUB, ACC_ADD, ACC_SUB.
  - Helper constants for the mode encodings.
- Sub-module elixirchip_es1_spu_op_addsub_lane: one lane's operand select, adder, accumulator and optional saturation. The top generates LANES instances plus the shared valid/delay pipeline.

Test Plan (LANES=2, DATA_BITS=8, LATENCY=2 unless noted):
- ADD: lane0 0xF0+0x20, carry 0, valid → 2 cycles later m_data lane0 = 0x10, m_carry=1, m_msb_c=1, m_valid=1. Lane1 0x01+0x01, carry 1 → 0x03, m_carry=0.
- SUB: 0x05−0x07 with s_carry=1 → 0xFE, m_carry=0. 0x07−0x05 → 0x02, m_carry=1.
- ACC_ADD: clear, then four valid beats of 0x40 interleaved with valid=0 gaps → outputs 0x40, 0x80, 0xC0, 0x00; m_carry=1 on the 4th beat only; m_valid high only for the beats.
- cke held low for 3 cycles with a beat in flight → outputs and acc frozen; the beat emerges 2 enabled cycles after entry.
- Reset low mid-accumulation (acc=0xC0) → outputs immediately 0/CLEAR values, m_valid=0. After release, ACC_ADD 0x10 → 0x10.
- With SATURATE_EN defined: ADD 0xF0+0x20 → 0xFF with m_carry=1. SUB 0x05−0x07 → 0x00. ACC_ADD saturates at 0xFF and stays.

Source files
------------

// File: rtl/elixirchip_es1_spu_op_addsub_acc_pkg.sv
// Shared mode encoding for the SPU add/subtract ops.
// Bit 0 selects subtract, bit 1 selects the accumulator as operand A.
package elixirchip_es1_spu_pkg;

    typedef enum logic [1:0] {
        MODE_ADD     = 2'b00,
        MODE_SUB     = 2'b01,
        MODE_ACC_ADD = 2'b10,
        MODE_ACC_SUB = 2'b11
    } mode_t;

    localparam int MODE_SUB_BIT = 0;
    localparam int MODE_ACC_BIT = 1;

    function automatic logic mode_is_sub(input mode_t mode);
        return mode[MODE_SUB_BIT];
    endfunction

    function automatic logic mode_is_acc(input mode_t mode);
        return mode[MODE_ACC_BIT];
    endfunction

endpackage

// File: rtl/elixirchip_es1_spu_op_addsub_lane.sv
// One SIMD lane: operand select, adder, accumulator and optional unsigned
// saturation (enabled by ELIXIRCHIP_ES1_SPU_OP_ADDSUB_SATURATE_EN).
module elixirchip_es1_spu_op_addsub_lane
    import elixirchip_es1_spu_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int CLEAR_DATA = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cke,
    input  mode_t                mode,
    input  logic                 carry_in,
    input  logic [DATA_BITS-1:0] data0,
    input  logic [DATA_BITS-1:0] data1,
    input  logic                 clear,
    input  logic                 valid,
    output logic [DATA_BITS-1:0] sum,
    output logic                 carry_out,
    output logic                 msb_c
);

    localparam logic [DATA_BITS-1:0] CLEAR_VALUE = DATA_BITS'(CLEAR_DATA);

    logic [DATA_BITS-1:0] acc_reg;
    logic [DATA_BITS-1:0] op_a;
    logic [DATA_BITS-1:0] op_b;
    logic [DATA_BITS-1:0] raw_sum;
    logic [DATA_BITS:0]   full_sum;

    always_comb begin
        op_a     = mode_is_acc(mode) ? acc_reg : data0;
        op_b     = mode_is_sub(mode) ? ~data1 : data1;
        full_sum = {1'b0, op_a} + {1'b0, op_b} + {{DATA_BITS{1'b0}}, carry_in};
    end

    assign raw_sum   = full_sum[DATA_BITS-1:0];
    assign carry_out = full_sum[DATA_BITS];
    // Carry into the MSB recovered from the MSB sum bit and its two operand bits.
    assign msb_c     = raw_sum[DATA_BITS-1] ^ op_a[DATA_BITS-1] ^ op_b[DATA_BITS-1];

`ifdef ELIXIRCHIP_ES1_SPU_OP_ADDSUB_SATURATE_EN
    assign sum = mode_is_sub(mode) ? (carry_out ? raw_sum : '0)
                                   : (carry_out ? '1 : raw_sum);
`else
    assign sum = raw_sum;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_reg <= CLEAR_VALUE;
        end else if (cke) begin
            if (clear) begin
                acc_reg <= CLEAR_VALUE;
            end else if (valid && mode_is_acc(mode)) begin
                acc_reg <= sum;
            end
        end
    end

endmodule

// File: rtl/elixirchip_es1_spu_op_addsub_acc.sv
// Multi-lane SPU add/subtract with per-lane accumulator and LATENCY-deep pipe.
// Optional saturation: define ELIXIRCHIP_ES1_SPU_OP_ADDSUB_SATURATE_EN.
module elixirchip_es1_spu_op_addsub_acc
    import elixirchip_es1_spu_pkg::*;
#(
    parameter int    LATENCY         = 1,
    parameter int    LANES           = 1,
    parameter int    DATA_BITS       = 8,
    parameter int    CLEAR_DATA      = 0,
    parameter int    CLEAR_CARRY     = 0,
    parameter int    IMMEDIATE_DATA1 = 0,
    parameter int    USE_CLEAR       = 1,
    parameter int    USE_VALID       = 1,
    parameter string DEVICE          = "RTL",
    parameter string SIMULATION      = "false",
    parameter string DEBUG           = "false"
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cke,
    input  logic [1:0]                 s_mode,
    input  logic [LANES-1:0]           s_carry,
    input  logic [LANES*DATA_BITS-1:0] s_data0,
    input  logic [LANES*DATA_BITS-1:0] s_data1,
    input  logic                       s_clear,
    input  logic                       s_valid,
    output logic [LANES*DATA_BITS-1:0] m_data,
    output logic [LANES-1:0]           m_carry,
    output logic [LANES-1:0]           m_msb_c,
    output logic                       m_valid
);

    localparam logic [LANES*DATA_BITS-1:0] CLEAR_VEC       = {LANES{DATA_BITS'(CLEAR_DATA)}};
    localparam logic [LANES-1:0]           CLEAR_CARRY_VEC = (CLEAR_CARRY != 0) ? '1 : '0;

    // Operand 1 has no input register, so there is nothing to trim for a
    // constant operand, and no target-specific structure exists.
    if (IMMEDIATE_DATA1 != 0 || DEVICE != "RTL" || SIMULATION == "true" || DEBUG == "true") begin : g_target_hints
    end

    mode_t mode;
    logic  clear_int;
    logic  valid_int;

    assign mode      = mode_t'(s_mode);
    assign clear_int = (USE_CLEAR != 0) ? s_clear : 1'b0;
    assign valid_int = (USE_VALID != 0) ? s_valid : 1'b1;

    logic [LANES*DATA_BITS-1:0] lane_sum;
    logic [LANES-1:0]           lane_carry;
    logic [LANES-1:0]           lane_msb_c;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        elixirchip_es1_spu_op_addsub_lane #(
            .DATA_BITS  (DATA_BITS),
            .CLEAR_DATA (CLEAR_DATA)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .cke       (cke),
            .mode      (mode),
            .carry_in  (s_carry[gi]),
            .data0     (s_data0[gi*DATA_BITS +: DATA_BITS]),
            .data1     (s_data1[gi*DATA_BITS +: DATA_BITS]),
            .clear     (clear_int),
            .valid     (valid_int),
            .sum       (lane_sum[gi*DATA_BITS +: DATA_BITS]),
            .carry_out (lane_carry[gi]),
            .msb_c     (lane_msb_c[gi])
        );
    end

    logic [LANES*DATA_BITS-1:0] data_reg  [LATENCY];
    logic [LANES-1:0]           carry_reg [LATENCY];
    logic [LANES-1:0]           msb_c_reg [LATENCY];
    logic [LATENCY-1:0]         valid_reg;

    // Stage 0 captures the lane results; later stages only delay, and each
    // stage's data loads only behind a valid beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < LATENCY; k++) begin
                data_reg[k]  <= CLEAR_VEC;
                carry_reg[k] <= CLEAR_CARRY_VEC;
                msb_c_reg[k] <= '0;
            end
            valid_reg <= '0;
        end else if (cke) begin
            valid_reg[0] <= valid_int;
            if (clear_int) begin
                data_reg[0]  <= CLEAR_VEC;
                carry_reg[0] <= CLEAR_CARRY_VEC;
                msb_c_reg[0] <= '0;
            end else if (valid_int) begin
                data_reg[0]  <= lane_sum;
                carry_reg[0] <= lane_carry;
                msb_c_reg[0] <= lane_msb_c;
            end
            for (int k = 1; k < LATENCY; k++) begin
                valid_reg[k] <= valid_reg[k-1];
                if (valid_reg[k-1]) begin
                    data_reg[k]  <= data_reg[k-1];
                    carry_reg[k] <= carry_reg[k-1];
                    msb_c_reg[k] <= msb_c_reg[k-1];
                end
            end
        end
    end

    assign m_data  = data_reg[LATENCY-1];
    assign m_carry = carry_reg[LATENCY-1];
    assign m_msb_c = msb_c_reg[LATENCY-1];
    assign m_valid = valid_reg[LATENCY-1];

endmodule

// File: tb/tb_elixirchip_es1_spu_op_addsub_acc.sv
// Scoreboard bench for elixirchip_es1_spu_op_addsub_acc (LANES=2, DATA_BITS=8, LATENCY=2).
module tb_elixirchip_es1_spu_op_addsub_acc;

    localparam int LATENCY = 2;
`ifdef ELIXIRCHIP_ES1_SPU_OP_ADDSUB_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        cke;
    logic [1:0]  s_mode;
    logic [1:0]  s_carry;
    logic [15:0] s_data0;
    logic [15:0] s_data1;
    logic        s_clear;
    logic        s_valid;
    logic [15:0] m_data;
    logic [1:0]  m_carry;
    logic [1:0]  m_msb_c;
    logic        m_valid;

    elixirchip_es1_spu_op_addsub_acc #(
        .LATENCY   (LATENCY),
        .LANES     (2),
        .DATA_BITS (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .cke     (cke),
        .s_mode  (s_mode),
        .s_carry (s_carry),
        .s_data0 (s_data0),
        .s_data1 (s_data1),
        .s_clear (s_clear),
        .s_valid (s_valid),
        .m_data  (m_data),
        .m_carry (m_carry),
        .m_msb_c (m_msb_c),
        .m_valid (m_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  carry;
        logic [1:0]  msb_c;
        int          en_at;
    } exp_t;

    exp_t exp_q[$];
    exp_t got_e;
    int   checks = 0;
    int   errors = 0;
    int   en_count = 0;
    logic last_en = 1'b0;

    function automatic void check(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, want);
        end
    endfunction

    // Enabled-edge counter lets the monitor verify latency across cke stalls.
    always @(posedge clk) begin
        last_en <= cke;
        if (cke) en_count <= en_count + 1;
    end

    always @(negedge clk) begin
        if (reset && last_en && m_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid got data %h with no beat expected", m_data);
            end else begin
                got_e = exp_q.pop_front();
                check("data", {16'h0, m_data}, {16'h0, got_e.data});
                check("carry", {30'h0, m_carry}, {30'h0, got_e.carry});
                check("msb_c", {30'h0, m_msb_c}, {30'h0, got_e.msb_c});
                check("latency", en_count, got_e.en_at);
                $display("beat data=%h carry=%b msb_c=%b at enabled edge %0d", m_data, m_carry, m_msb_c, en_count);
            end
        end
    end

    task automatic beat(input logic [1:0] mode, input logic [1:0] c,
                        input logic [15:0] d0, input logic [15:0] d1,
                        input logic clr, input logic vld,
                        input logic [15:0] edata, input logic [1:0] ecarry,
                        input logic [1:0] emsbc);
        exp_t e;
        @(posedge clk);
        #1;
        cke     = 1'b1;
        s_mode  = mode;
        s_carry = c;
        s_data0 = d0;
        s_data1 = d1;
        s_clear = clr;
        s_valid = vld;
        if (vld) begin
            e.data  = edata;
            e.carry = ecarry;
            e.msb_c = emsbc;
            e.en_at = en_count + LATENCY;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_clear = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_data"}, {16'h0, m_data}, 32'h0);
        check({tag, "_m_carry"}, {30'h0, m_carry}, 32'h0);
        check({tag, "_m_msb_c"}, {30'h0, m_msb_c}, 32'h0);
        check({tag, "_m_valid"}, {31'h0, m_valid}, 32'h0);
    endtask

    initial begin
        reset = 1'b0; cke = 1'b1; s_mode = 2'b00; s_carry = 2'b00;
        s_data0 = 16'h0; s_data1 = 16'h0; s_clear = 1'b0; s_valid = 1'b0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // ADD and SUB, lane1 in the high byte
        beat(2'b00, 2'b10, 16'h01F0, 16'h0120, 1'b0, 1'b1, SAT ? 16'h03FF : 16'h0310, 2'b01, 2'b01);
        beat(2'b01, 2'b11, 16'h0705, 16'h0507, 1'b0, 1'b1, SAT ? 16'h0200 : 16'h02FE, 2'b10, 2'b10);
        idle(); idle();

        // Accumulate 0x40 / 0x01 with idle gaps; data0 must be ignored
        beat(2'b10, 2'b00, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0, 2'b00, 2'b00);
        beat(2'b10, 2'b00, 16'h5555, 16'h0140, 1'b0, 1'b1, 16'h0140, 2'b00, 2'b00); idle();
        beat(2'b10, 2'b00, 16'h5555, 16'h0140, 1'b0, 1'b1, 16'h0280, 2'b00, 2'b01); idle();
        beat(2'b10, 2'b00, 16'h5555, 16'h0140, 1'b0, 1'b1, 16'h03C0, 2'b00, 2'b00); idle();
        beat(2'b10, 2'b00, 16'h5555, 16'h0140, 1'b0, 1'b1, SAT ? 16'h04FF : 16'h0400, 2'b01, 2'b01); idle();
        beat(2'b10, 2'b00, 16'h5555, 16'h0140, 1'b0, 1'b1, SAT ? 16'h05FF : 16'h0540,
             SAT ? 2'b01 : 2'b00, SAT ? 2'b01 : 2'b00);
        idle(); idle();

        // Clear, rebuild to 0xC0, then reset while that result is on the output
        beat(2'b10, 2'b00, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0, 2'b00, 2'b00);
        beat(2'b10, 2'b00, 16'h0, 16'h0140, 1'b0, 1'b1, 16'h0140, 2'b00, 2'b00); idle();
        beat(2'b10, 2'b00, 16'h0, 16'h0140, 1'b0, 1'b1, 16'h0280, 2'b00, 2'b01); idle();
        beat(2'b10, 2'b00, 16'h0, 16'h0140, 1'b0, 1'b1, 16'h03C0, 2'b00, 2'b00);
        idle();
        @(posedge clk);
        @(negedge clk);
        #2;
        check("pre_reset_valid", {31'h0, m_valid}, 32'h1);
        check("pre_reset_data", {16'h0, m_data}, 32'h03C0);
        reset = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        beat(2'b10, 2'b00, 16'h0, 16'h2210, 1'b0, 1'b1, 16'h2210, 2'b00, 2'b00);
        idle(); idle(); idle();

        // Stall with a beat in flight; junk ACC beats during the stall are ignored
        beat(2'b00, 2'b00, 16'h7F12, 16'h0134, 1'b0, 1'b1, 16'h8046, 2'b00, 2'b10);
        @(posedge clk);
        #1;
        cke = 1'b0; s_valid = 1'b1; s_mode = 2'b10; s_data1 = 16'hFFFF;
        repeat (3) begin
            @(negedge clk);
            check("frozen_valid", {31'h0, m_valid}, 32'h0);
            check("frozen_data", {16'h0, m_data}, 32'h2210);
        end
        @(posedge clk);
        #1;
        cke = 1'b1; s_valid = 1'b0;
        idle();
        beat(2'b10, 2'b00, 16'h0, 16'h0101, 1'b0, 1'b1, 16'h2311, 2'b00, 2'b00); idle();

        // Clear together with valid: cleared beat still emerges
        beat(2'b10, 2'b11, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 16'h0000, 2'b00, 2'b00); idle();
        beat(2'b10, 2'b00, 16'h0, 16'h0101, 1'b0, 1'b1, 16'h0101, 2'b00, 2'b00);
        repeat (4) idle();

        check("queue_drained", exp_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
